// File: rtl/clock_ctrl_pkg.sv
// Shared state encoding, BCD limits and shadow-time helpers for the time-set controller.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StSetHour = 2'd1,
        StSetMin  = 2'd2,
        StCommit  = 2'd3
    } state_e;

    localparam logic [1:0] HOUR_MAX_TENS      = 2'd2;
    localparam logic [3:0] HOUR_MAX_ONES_AT_2 = 4'd3;
    localparam logic [2:0] MIN_MAX_TENS       = 3'd5;
    localparam logic [3:0] BCD_MAX            = 4'd9;

    typedef struct packed {
        logic [1:0] h_tens;
        logic [3:0] h_ones;
        logic [2:0] m_tens;
        logic [3:0] m_ones;
    } hhmm_t;

    // 23 -> 00; minutes untouched.
    function automatic hhmm_t inc_hour(input hhmm_t t);
        hhmm_t r;
        r = t;
        if (t.h_tens == HOUR_MAX_TENS && t.h_ones == HOUR_MAX_ONES_AT_2) begin
            r.h_tens = 2'd0;
            r.h_ones = 4'd0;
        end else if (t.h_ones == BCD_MAX) begin
            r.h_tens = t.h_tens + 2'd1;
            r.h_ones = 4'd0;
        end else begin
            r.h_ones = t.h_ones + 4'd1;
        end
        return r;
    endfunction

    // 59 -> 00 with no carry into hours.
    function automatic hhmm_t inc_min(input hhmm_t t);
        hhmm_t r;
        r = t;
        if (t.m_ones == BCD_MAX) begin
            r.m_ones = 4'd0;
            r.m_tens = (t.m_tens == MIN_MAX_TENS) ? 3'd0 : t.m_tens + 3'd1;
        end else begin
            r.m_ones = t.m_ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button to debounced press pulse: 2-flop sync, tick-based stability filter, optional
// auto-repeat while held.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned REPEAT_DELAY_MS = 600,
    parameter int unsigned REPEAT_MS       = 150
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic press
);

    localparam int unsigned DW = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned RW = $clog2(REPEAT_DELAY_MS + REPEAT_MS + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          armed_q, armed_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rep_q, rep_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        armed_d = armed_q;
        press_d = 1'b0;

        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == DW'(DEBOUNCE_MS - 1)) begin
                cnt_d   = '0;
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // First repeat after the long delay, then at the shorter period.
        if (REPEAT_EN) begin
            if (!level_q) begin
                rep_d   = '0;
                armed_d = 1'b0;
            end else if (tick) begin
                if (rep_q == RW'(armed_q ? REPEAT_MS - 1 : REPEAT_DELAY_MS - 1)) begin
                    rep_d   = '0;
                    armed_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            rep_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// HH:MM time-set controller: freezes the counters, edits a shadow copy of hours then minutes,
// commits with a one-cycle load and blinks the field under edit.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned REPEAT_DELAY_MS = 600,
    parameter int unsigned REPEAT_MS       = 150,
    parameter int unsigned BLINK_MS        = 250,
    parameter int unsigned TIMEOUT_MS      = 10000
) (
    input  logic       clk0,
    input  logic       rst,
    input  logic       tick_1ms,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [1:0] cur_h_tens,
    input  logic [3:0] cur_h_ones,
    input  logic [2:0] cur_m_tens,
    input  logic [3:0] cur_m_ones,
    output logic       run_en,
    output logic       load,
    output logic [1:0] set_h_tens,
    output logic [3:0] set_h_ones,
    output logic [2:0] set_m_tens,
    output logic [3:0] set_m_ones,
    output logic [3:0] blank_mask,
    output logic [1:0] mode
);

    localparam int unsigned IW = $clog2(TIMEOUT_MS + 1);
    localparam int unsigned BW = $clog2(BLINK_MS + 1);

    logic          ev_mode, ev_inc;
    state_e        state_q, state_d;
    hhmm_t         sh_q, sh_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          tog_q, tog_d;
    logic          run_en_q, run_en_d, load_q, load_d;
    logic [3:0]    blank_q, blank_d;

    btn_debounce #(
        .DEBOUNCE_MS     (DEBOUNCE_MS),
        .REPEAT_EN       (1'b0),
        .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
        .REPEAT_MS       (REPEAT_MS)
    ) u_mode_btn (
        .clk   (clk0),
        .rst   (rst),
        .tick  (tick_1ms),
        .btn   (btn_mode),
        .press (ev_mode)
    );

    btn_debounce #(
        .DEBOUNCE_MS     (DEBOUNCE_MS),
        .REPEAT_EN       (1'b1),
        .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
        .REPEAT_MS       (REPEAT_MS)
    ) u_inc_btn (
        .clk   (clk0),
        .rst   (rst),
        .tick  (tick_1ms),
        .btn   (btn_inc),
        .press (ev_inc)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idle_d  = idle_q;
        blink_d = blink_q;
        tog_d   = tog_q;

        unique case (state_q)
            StRun: begin
                if (ev_mode) begin
                    state_d     = StSetHour;
                    sh_d.h_tens = cur_h_tens;
                    sh_d.h_ones = cur_h_ones;
                    sh_d.m_tens = cur_m_tens;
                    sh_d.m_ones = cur_m_ones;
                    idle_d      = '0;
                    blink_d     = '0;
                    tog_d       = 1'b0;
                end
            end
            StSetHour, StSetMin: begin
                // MODE has priority; a same-cycle INC is dropped.
                if (ev_mode) begin
                    state_d = (state_q == StSetHour) ? StSetMin : StCommit;
                    idle_d  = '0;
                    blink_d = '0;
                    tog_d   = 1'b0;
                end else if (ev_inc) begin
                    sh_d    = (state_q == StSetHour) ? inc_hour(sh_q) : inc_min(sh_q);
                    idle_d  = '0;
                    blink_d = '0;
                    tog_d   = 1'b0;
                end else if (tick_1ms) begin
                    if (idle_q == IW'(TIMEOUT_MS - 1)) begin
                        state_d = StRun;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                    if (blink_q == BW'(BLINK_MS - 1)) begin
                        blink_d = '0;
                        tog_d   = ~tog_q;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                end
            end
            StCommit: state_d = StRun;
            default:  state_d = StRun;
        endcase

        run_en_d = (state_d == StRun);
        load_d   = (state_d == StCommit);
        blank_d  = 4'b0000;
        if (tog_d && state_d == StSetHour) blank_d = 4'b1100;
        if (tog_d && state_d == StSetMin)  blank_d = 4'b0011;
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            state_q  <= StRun;
            sh_q     <= '0;
            idle_q   <= '0;
            blink_q  <= '0;
            tog_q    <= 1'b0;
            run_en_q <= 1'b1;
            load_q   <= 1'b0;
            blank_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            idle_q   <= idle_d;
            blink_q  <= blink_d;
            tog_q    <= tog_d;
            run_en_q <= run_en_d;
            load_q   <= load_d;
            blank_q  <= blank_d;
        end
    end

    assign run_en     = run_en_q;
    assign load       = load_q;
    assign set_h_tens = sh_q.h_tens;
    assign set_h_ones = sh_q.h_ones;
    assign set_m_tens = sh_q.m_tens;
    assign set_m_ones = sh_q.m_ones;
    assign blank_mask = blank_q;
    assign mode       = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: table of button presses with expected shadow/mode,
// plus hand sequences for auto-repeat, blink, timeout, simultaneous press and reset in COMMIT.
module tb_clock_set_ctrl;

    logic       clk0 = 1'b0;
    logic       rst;
    logic       tick_1ms;
    logic       btn_mode, btn_inc;
    logic [1:0] cur_h_tens;
    logic [3:0] cur_h_ones;
    logic [2:0] cur_m_tens;
    logic [3:0] cur_m_ones;
    logic       run_en, load;
    logic [1:0] set_h_tens;
    logic [3:0] set_h_ones;
    logic [2:0] set_m_tens;
    logic [3:0] set_m_ones;
    logic [3:0] blank_mask;
    logic [1:0] mode;

    int errors = 0;
    int checks = 0;

    clock_set_ctrl #(
        .DEBOUNCE_MS     (3),
        .REPEAT_DELAY_MS (10),
        .REPEAT_MS       (4),
        .BLINK_MS        (8),
        .TIMEOUT_MS      (60)
    ) dut (
        .clk0       (clk0),
        .rst        (rst),
        .tick_1ms   (tick_1ms),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cur_h_tens (cur_h_tens),
        .cur_h_ones (cur_h_ones),
        .cur_m_tens (cur_m_tens),
        .cur_m_ones (cur_m_ones),
        .run_en     (run_en),
        .load       (load),
        .set_h_tens (set_h_tens),
        .set_h_ones (set_h_ones),
        .set_m_tens (set_m_tens),
        .set_m_ones (set_m_ones),
        .blank_mask (blank_mask),
        .mode       (mode)
    );

    always #5 clk0 = ~clk0;

    // One tick every 4 clocks.
    logic [1:0] tdiv = 2'd0;
    always @(posedge clk0) tdiv <= tdiv + 2'd1;
    assign tick_1ms = (tdiv == 2'd3);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Returns at the negedge just after the DUT has consumed one tick.
    task automatic wait_tick();
        @(negedge clk0);
        while (!tick_1ms) @(negedge clk0);
        @(negedge clk0);
    endtask

    task automatic press(input logic pm, input logic pi, input int n);
        wait_tick();
        btn_mode = pm;
        btn_inc  = pi;
        repeat (n) wait_tick();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (5) wait_tick();
    endtask

    function automatic logic [12:0] shadow();
        return {set_h_tens, set_h_ones, set_m_tens, set_m_ones};
    endfunction

    // Load monitor: every load must carry the expected value, happen in COMMIT and be
    // followed by RUN with run_en on the next cycle.
    int          load_cnt = 0;
    bit          after_load = 1'b0;
    logic [12:0] exp_load;
    always @(negedge clk0) begin
        if (after_load) begin
            check("post_load_run_en", {31'd0, run_en}, 32'd1);
            check("post_load_mode", {30'd0, mode}, 32'd0);
            check("post_load_load", {31'd0, load}, 32'd0);
            after_load = 1'b0;
        end
        if (load === 1'b1) begin
            load_cnt++;
            check("load_mode", {30'd0, mode}, 32'd3);
            check("load_value", {19'd0, shadow()}, {19'd0, exp_load});
            after_load = 1'b1;
        end
    end

    // Increment monitor for the auto-repeat test.
    bit         hold_mon = 1'b0;
    int         inc_seen = 0;
    logic [6:0] prev_m = 7'd0;
    always @(negedge clk0) begin
        if (hold_mon && {set_m_tens, set_m_ones} != prev_m) begin
            inc_seen++;
            check("blank_on_inc", {28'd0, blank_mask}, 32'd0);
        end
        prev_m = {set_m_tens, set_m_ones};
    end

    typedef struct {
        bit          is_inc;
        logic [12:0] exp_sh;
        logic [1:0]  exp_mode;
        logic        exp_run;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Start 22:58, walk hours 22->23->00->01, minutes 58->59->00, commit 01:00.
        vecs[0] = '{1'b0, {2'd2, 4'd2, 3'd5, 4'd8}, 2'd1, 1'b0};
        vecs[1] = '{1'b1, {2'd2, 4'd3, 3'd5, 4'd8}, 2'd1, 1'b0};
        vecs[2] = '{1'b1, {2'd0, 4'd0, 3'd5, 4'd8}, 2'd1, 1'b0};
        vecs[3] = '{1'b1, {2'd0, 4'd1, 3'd5, 4'd8}, 2'd1, 1'b0};
        vecs[4] = '{1'b0, {2'd0, 4'd1, 3'd5, 4'd8}, 2'd2, 1'b0};
        vecs[5] = '{1'b1, {2'd0, 4'd1, 3'd5, 4'd9}, 2'd2, 1'b0};
        vecs[6] = '{1'b1, {2'd0, 4'd1, 3'd0, 4'd0}, 2'd2, 1'b0};
        vecs[7] = '{1'b0, {2'd0, 4'd1, 3'd0, 4'd0}, 2'd0, 1'b1};

        rst = 1'b1;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        {cur_h_tens, cur_h_ones, cur_m_tens, cur_m_ones} = 13'd0;
        repeat (4) @(negedge clk0);
        check("rst_mode", {30'd0, mode}, 32'd0);
        check("rst_run_en", {31'd0, run_en}, 32'd1);
        check("rst_load", {31'd0, load}, 32'd0);
        check("rst_blank", {28'd0, blank_mask}, 32'd0);
        check("rst_shadow", {19'd0, shadow()}, 32'd0);
        rst = 1'b0;

        // Two-tick glitch must not be accepted.
        press(1'b1, 1'b0, 2);
        check("glitch_mode", {30'd0, mode}, 32'd0);
        check("glitch_run_en", {31'd0, run_en}, 32'd1);

        {cur_h_tens, cur_h_ones, cur_m_tens, cur_m_ones} = {2'd2, 4'd2, 3'd5, 4'd8};
        exp_load = {2'd0, 4'd1, 3'd0, 4'd0};
        for (int i = 0; i < 8; i++) begin
            press(!vecs[i].is_inc, vecs[i].is_inc, 5);
            check($sformatf("vec%0d_shadow", i), {19'd0, shadow()}, {19'd0, vecs[i].exp_sh});
            check($sformatf("vec%0d_mode", i), {30'd0, mode}, {30'd0, vecs[i].exp_mode});
            check($sformatf("vec%0d_run_en", i), {31'd0, run_en}, {31'd0, vecs[i].exp_run});
        end
        check("load_count_1", load_cnt, 1);

        // Capture 13:47 and watch the hour field blink.
        {cur_h_tens, cur_h_ones, cur_m_tens, cur_m_ones} = {2'd1, 4'd3, 3'd4, 4'd7};
        press(1'b1, 1'b0, 5);
        check("cap_mode", {30'd0, mode}, 32'd1);
        check("cap_run_en", {31'd0, run_en}, 32'd0);
        check("cap_shadow", {19'd0, shadow()}, {19'd0, 2'd1, 4'd3, 3'd4, 4'd7});
        check("blink_before", {28'd0, blank_mask}, 32'd0);
        wait_tick();
        check("blink_on", {28'd0, blank_mask}, 32'hC);
        repeat (8) wait_tick();
        check("blink_off", {28'd0, blank_mask}, 32'd0);

        // Auto-repeat: initial press plus 6 repeats over the hold.
        press(1'b1, 1'b0, 5);
        check("to_min_mode", {30'd0, mode}, 32'd2);
        hold_mon = 1'b1;
        press(1'b0, 1'b1, 33);
        hold_mon = 1'b0;
        check("repeat_count", inc_seen, 7);
        check("repeat_shadow", {19'd0, shadow()}, {19'd0, 2'd1, 4'd3, 3'd5, 4'd4});

        exp_load = {2'd1, 4'd3, 3'd5, 4'd4};
        press(1'b1, 1'b0, 5);
        check("commit2_mode", {30'd0, mode}, 32'd0);
        check("load_count_2", load_cnt, 2);

        // Idle timeout from SET_HOUR: back to RUN without a load.
        press(1'b1, 1'b0, 5);
        check("to_hour_mode", {30'd0, mode}, 32'd1);
        repeat (70) wait_tick();
        check("timeout_mode", {30'd0, mode}, 32'd0);
        check("timeout_run_en", {31'd0, run_en}, 32'd1);
        check("timeout_blank", {28'd0, blank_mask}, 32'd0);
        check("timeout_no_load", load_cnt, 2);

        // Simultaneous MODE and INC: MODE wins, hours unchanged.
        press(1'b1, 1'b0, 5);
        press(1'b1, 1'b1, 5);
        check("both_mode", {30'd0, mode}, 32'd2);
        check("both_shadow", {19'd0, shadow()}, {19'd0, 2'd1, 4'd3, 3'd4, 4'd7});

        // Reset asserted during the COMMIT cycle.
        exp_load = {2'd1, 4'd3, 3'd4, 4'd7};
        wait_tick();
        btn_mode = 1'b1;
        for (int i = 0; i < 200 && load !== 1'b1; i++) @(negedge clk0);
        check("commit_reached", {31'd0, load}, 32'd1);
        rst = 1'b1;
        btn_mode = 1'b0;
        @(negedge clk0);
        check("rstc_load", {31'd0, load}, 32'd0);
        check("rstc_mode", {30'd0, mode}, 32'd0);
        check("rstc_run_en", {31'd0, run_en}, 32'd1);
        check("rstc_blank", {28'd0, blank_mask}, 32'd0);
        check("rstc_shadow", {19'd0, shadow()}, 32'd0);
        repeat (3) @(negedge clk0);
        rst = 1'b0;
        repeat (4) @(negedge clk0);
        check("load_count_3", load_cnt, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
